// File: rtl/vip_uart_pkg.sv
// Shared types for the multi-channel UART receiver VIP.
// Parity modes, lane FSM states and the per-byte FIFO entry.
package vip_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } uart_rx_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Power-of-two FIFO; a push into a full FIFO lands only when a pop
// frees the slot in the same cycle.
module fifo_v3 #(
  parameter int unsigned DEPTH = 8,
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  dtype          mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vip_uart_rx_lane.sv
// One UART receive lane: 2-flop synchroniser, bit counter and frame FSM.
// push_o pulses in the cycle the stop bit is sampled.
module vip_uart_rx_lane
  import vip_uart_pkg::*;
#(
  parameter int unsigned ClkPerBit  = 16,
  parameter int unsigned ParityMode = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rx_i,
  output logic           push_o,
  output uart_rx_entry_t entry_o,
  output logic           busy_o
);

  localparam int unsigned CW = $clog2(ClkPerBit);
  localparam logic [CW-1:0] HalfBit = CW'(ClkPerBit / 2 - 1);
  localparam logic [CW-1:0] FullBit = CW'(ClkPerBit - 1);

  logic           sync_q, rx_s_q, rx_d_q;
  uart_rx_state_e state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     data_q;
  logic           perr_q;
  logic           tick;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= rx_i;
      rx_s_q <= sync_q;
      rx_d_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          if (rx_d_q && !rx_s_q) begin
            cnt_q   <= HalfBit;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_s_q) begin
            state_q <= RX_IDLE;
          end else begin
            cnt_q   <= FullBit;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            state_q <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            data_q <= {rx_s_q, data_q[7:1]};
            cnt_q  <= FullBit;
            bit_q  <= bit_q + 1'b1;
            if (bit_q == 3'd7)
              state_q <= (ParityMode != 0) ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (!tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            perr_q  <= (^data_q) ^ rx_s_q
                     ^ (ParityMode == int'(PAR_ODD));
            cnt_q   <= FullBit;
            state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (!tick) cnt_q <= cnt_q - 1'b1;
          else       state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign push_o       = (state_q == RX_STOP) && tick;
  assign entry_o.data = data_q;
  assign entry_o.ferr = !rx_s_q;
  assign entry_o.perr = perr_q;
  assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: rtl/vip_uart_rx_array.sv
// NumChan UART receive lanes, each buffered in a FIFO and merged
// round-robin into one registered valid/ready byte stream.
module vip_uart_rx_array
  import vip_uart_pkg::*;
#(
  parameter int unsigned NumChan    = 4,
  parameter int unsigned ClkPerBit  = 16,
  parameter int unsigned ParityMode = 0,
  parameter int unsigned FifoDepth  = 8,
  localparam int unsigned ChW = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumChan-1:0] rx_i,
  input  logic               clr_i,
  output logic [7:0]         data_o,
  output logic [ChW-1:0]     chan_o,
  output logic               ferr_o,
  output logic               perr_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [NumChan-1:0] ovf_o,
  output logic [NumChan-1:0] busy_o
);

  logic [NumChan-1:0] push, full, empty, pop, ovf_set;
  uart_rx_entry_t     lane_entry [NumChan];
  uart_rx_entry_t     fifo_q     [NumChan];

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    vip_uart_rx_lane #(
      .ClkPerBit (ClkPerBit),
      .ParityMode(ParityMode)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .rx_i   (rx_i[c]),
      .push_o (push[c]),
      .entry_o(lane_entry[c]),
      .busy_o (busy_o[c])
    );

    fifo_v3 #(
      .DEPTH(FifoDepth),
      .dtype(uart_rx_entry_t)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (1'b1),
      .flush_i(rst_i),
      .full_o (full[c]),
      .empty_o(empty[c]),
      .data_i (lane_entry[c]),
      .push_i (push[c]),
      .data_o (fifo_q[c]),
      .pop_i  (pop[c])
    );
  end

  // A simultaneous pop frees room, so only an unpopped full FIFO overflows.
  assign ovf_set = push & full & ~pop;

  logic [ChW-1:0] ptr_q, gnt_idx;
  logic           gnt_valid, load;

  always_comb begin
    int unsigned j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = ptr_q;
    for (int unsigned i = 0; i < NumChan; i++) begin
      j = (int'(ptr_q) + i) % NumChan;
      if (!gnt_valid && !empty[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ChW'(j);
      end
    end
  end

  assign load = gnt_valid && (!valid_o || ready_i);
  assign pop  = load ? (NumChan'(1) << gnt_idx) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      chan_o  <= '0;
      ferr_o  <= 1'b0;
      perr_o  <= 1'b0;
      valid_o <= 1'b0;
      ptr_q   <= '0;
    end else if (load) begin
      data_o  <= fifo_q[gnt_idx].data;
      chan_o  <= gnt_idx;
      ferr_o  <= fifo_q[gnt_idx].ferr;
      perr_o  <= fifo_q[gnt_idx].perr;
      valid_o <= 1'b1;
      ptr_q   <= (gnt_idx == ChW'(NumChan - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_o <= '0;
    else       ovf_o <= ovf_set | (ovf_o & ~{NumChan{clr_i}});
  end

endmodule

// File: tb/tb_vip_uart_rx_array.sv
// Directed bench for vip_uart_rx_array: one instance without parity,
// one with even parity, both with 4 channels and 16 clocks per bit.
module tb_vip_uart_rx_array;

  logic       clk = 1'b0;
  logic       rst, clr, ready, ready_p;
  logic [3:0] rx, rxp;

  logic [7:0] data, data_p;
  logic [1:0] chan, chan_p;
  logic       ferr, perr, valid, ferr_p, perr_p, valid_p;
  logic [3:0] ovf, busy, ovf_p, busy_p;

  int ntests = 0;
  int nfail  = 0;
  logic [10:0] frm [4];

  always #5 clk = ~clk;

  vip_uart_rx_array #(
    .NumChan(4), .ClkPerBit(16), .ParityMode(0), .FifoDepth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .clr_i(clr),
    .data_o(data), .chan_o(chan), .ferr_o(ferr), .perr_o(perr),
    .valid_o(valid), .ready_i(ready), .ovf_o(ovf), .busy_o(busy)
  );

  vip_uart_rx_array #(
    .NumChan(4), .ClkPerBit(16), .ParityMode(1), .FifoDepth(8)
  ) dut_p (
    .clk_i(clk), .rst_i(rst), .rx_i(rxp), .clr_i(clr),
    .data_o(data_p), .chan_o(chan_p), .ferr_o(ferr_p), .perr_o(perr_p),
    .valid_o(valid_p), .ready_i(ready_p), .ovf_o(ovf_p), .busy_o(busy_p)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input bit sel, input string tag, input logic [7:0] d,
                      input logic [1:0] ch, input logic fe, input logic pe);
    if (sel)
      check(tag, {19'd0, valid_p, data_p, chan_p, ferr_p, perr_p},
                 {19'd0, 1'b1, d, ch, fe, pe});
    else
      check(tag, {19'd0, valid, data, chan, ferr, perr},
                 {19'd0, 1'b1, d, ch, fe, pe});
  endtask

  // Drives frame bits lo..hi of frm[] on the masked lines, 16 clocks each.
  task automatic send_bits(input bit sel, input logic [3:0] mask,
                           input int lo, input int hi);
    for (int b = lo; b <= hi; b++) begin
      for (int c = 0; c < 4; c++)
        if (mask[c]) begin
          if (sel) rxp[c] = frm[c][b];
          else     rx[c]  = frm[c][b];
        end
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic drain(input bit sel);
    if (sel) ready_p = 1'b1; else ready = 1'b1;
    @(negedge clk);
    ready_p = 1'b0;
    ready   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ready = 1'b0; ready_p = 1'b0;
    rx = '1; rxp = '1;
    for (int c = 0; c < 4; c++) frm[c] = '1;
    repeat (3) @(negedge clk);
    check("rst_out", {valid, data, chan, ferr, perr, ovf, busy}, 0);
    check("rst_out_p", {valid_p, data_p, chan_p, ferr_p, perr_p,
                        ovf_p, busy_p}, 0);
    rst = 1'b0;
    @(negedge clk);

    // single byte on ch0, latency from stop sample
    frm[0] = {2'b11, 8'hA5, 1'b0};
    send_bits(0, 4'b0001, 0, 8);
    rx[0] = 1'b1;
    repeat (11) @(negedge clk);
    check("lat_pre", {31'd0, valid}, 0);
    @(negedge clk);
    beat(0, "a5", 8'hA5, 2'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    beat(0, "a5_hold", 8'hA5, 2'd0, 1'b0, 1'b0);
    drain(0);
    check("a5_drained", {31'd0, valid}, 0);

    // short low pulse on ch1 is rejected at the start-bit sample
    rx[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", {28'd0, busy}, 4'b0010);
    @(negedge clk);
    rx[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_idle", {28'd0, busy}, 0);
    repeat (160) @(negedge clk);
    check("glitch_nopush", {31'd0, valid}, 0);

    // even parity on ch2
    frm[2] = {1'b1, 1'b0, 8'h07, 1'b0};
    send_bits(1, 4'b0100, 0, 10);
    repeat (4) @(negedge clk);
    beat(1, "par_bad", 8'h07, 2'd2, 1'b0, 1'b1);
    drain(1);
    frm[2] = {1'b1, 1'b1, 8'h07, 1'b0};
    send_bits(1, 4'b0100, 0, 10);
    repeat (4) @(negedge clk);
    beat(1, "par_ok", 8'h07, 2'd2, 1'b0, 1'b0);
    drain(1);

    // framing error on ch3, then two frames with no idle gap
    frm[3] = {2'b10, 8'h3C, 1'b0};
    send_bits(0, 4'b1000, 0, 9);
    rx[3] = 1'b1;
    repeat (16) @(negedge clk);
    frm[3] = {2'b11, 8'h5A, 1'b0};
    send_bits(0, 4'b1000, 0, 9);
    frm[3] = {2'b11, 8'hC3, 1'b0};
    send_bits(0, 4'b1000, 0, 9);
    repeat (20) @(negedge clk);
    beat(0, "ferr", 8'h3C, 2'd3, 1'b1, 1'b0);
    drain(0);
    beat(0, "b2b_1", 8'h5A, 2'd3, 1'b0, 1'b0);
    drain(0);
    beat(0, "b2b_2", 8'hC3, 2'd3, 1'b0, 1'b0);
    drain(0);
    check("b2b_empty", {31'd0, valid}, 0);

    // all four lanes finish together, pointer at 0
    ready = 1'b1;
    for (int c = 0; c < 4; c++) frm[c] = {2'b11, 8'h41 + 8'(c), 1'b0};
    send_bits(0, 4'b1111, 0, 8);
    rx = '1;
    repeat (12) @(negedge clk);
    beat(0, "rr_0", 8'h41, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    beat(0, "rr_1", 8'h42, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    beat(0, "rr_2", 8'h43, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    beat(0, "rr_3", 8'h44, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("rr_done", {31'd0, valid}, 0);

    // a ch1 grant leaves the pointer at 2, so ch3 goes first
    frm[1] = {2'b11, 8'h55, 1'b0};
    send_bits(0, 4'b0010, 0, 9);
    repeat (8) @(negedge clk);
    frm[0] = {2'b11, 8'h60, 1'b0};
    frm[1] = {2'b11, 8'h61, 1'b0};
    frm[3] = {2'b11, 8'h63, 1'b0};
    send_bits(0, 4'b1011, 0, 8);
    rx = '1;
    repeat (12) @(negedge clk);
    beat(0, "rr2_3", 8'h63, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    beat(0, "rr2_0", 8'h60, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    beat(0, "rr2_1", 8'h61, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("rr2_done", {31'd0, valid}, 0);
    ready = 1'b0;

    // overflow: slot + 8 FIFO entries hold, tenth byte dropped
    for (int k = 0; k < 10; k++) begin
      frm[0] = {2'b11, 8'h10 + 8'(k), 1'b0};
      send_bits(0, 4'b0001, 0, 9);
      if (k == 8) check("ovf_pre", {28'd0, ovf}, 0);
    end
    repeat (4) @(negedge clk);
    check("ovf_set", {28'd0, ovf}, 4'b0001);
    for (int k = 0; k < 9; k++) begin
      beat(0, $sformatf("ovf_d%0d", k), 8'h10 + 8'(k), 2'd0, 1'b0, 1'b0);
      drain(0);
    end
    check("ovf_drop", {31'd0, valid}, 0);
    check("ovf_sticky", {28'd0, ovf}, 4'b0001);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovf_clr", {28'd0, ovf}, 0);

    // reset in the middle of a ch1 frame
    frm[1] = {2'b11, 8'hF0, 1'b0};
    send_bits(0, 4'b0010, 0, 4);
    check("mid_busy", {28'd0, busy}, 4'b0010);
    rx[1] = 1'b1;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_abort", {27'd0, valid, busy}, 0);
    repeat (40) @(negedge clk);
    check("rst_nobeat", {27'd0, valid, busy}, 0);
    frm[1] = {2'b11, 8'h96, 1'b0};
    send_bits(0, 4'b0010, 0, 9);
    repeat (4) @(negedge clk);
    beat(0, "post_rst", 8'h96, 2'd1, 1'b0, 1'b0);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
